// File: rtl/mac_accumulator.sv
// mac_accumulator: valid/ready multiply-accumulate stage emitting one sum per operand vector; define MAC_ACC_SATURATE_EN to clamp acc on carry instead of wrapping
module mac_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int MAX_TERMS  = 16,
  localparam int CW = $clog2(MAX_TERMS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [ACC_WIDTH-1:0]  acc_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic [CW-1:0]         term_count
);
  typedef enum logic {ACCUM, DONE} state_t;
  state_t state, state_nxt;
  logic [ACC_WIDTH-1:0] acc, acc_nxt;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH:0] sum;
  logic [CW-1:0] cnt_nxt;
  logic first, xfer, eov, carry;
  assign prod = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
  assign sum = {1'b0, first ? {ACC_WIDTH{1'b0}} : acc} + {{(ACC_WIDTH + 1 - 2*DATA_WIDTH){1'b0}}, prod};
  assign carry = sum[ACC_WIDTH];
`ifdef MAC_ACC_SATURATE_EN
  assign acc_nxt = carry ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
  assign acc_nxt = sum[ACC_WIDTH-1:0];
`endif
  assign cnt_nxt = first ? CW'(1) : term_count + 1'b1;
  assign eov = in_last || (cnt_nxt == CW'(MAX_TERMS));
  assign xfer = in_valid && in_ready;
  assign acc_out = acc;
  always_ff @(posedge clk)
    state <= rst ? ACCUM : state_nxt;
  always_comb
    state_nxt = (state == ACCUM) ? ((xfer && eov) ? DONE : ACCUM) : (out_ready ? ACCUM : DONE);
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      first      <= 1'b1;
      overflow   <= 1'b0;
      term_count <= '0;
    end else if (xfer) begin
      acc        <= acc_nxt;
      first      <= eov;
      overflow   <= (!first && overflow) || carry;
      term_count <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed self-checking bench for mac_accumulator (DATA_WIDTH=8, ACC_WIDTH=16, MAX_TERMS=4)
module tb_mac_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, overflow;
  logic [15:0] acc_out;
  logic [2:0] term_count;
  int total = 0;
  int bad = 0;
  mac_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(16), .MAX_TERMS(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .term_count(term_count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic last);
    a = x;
    b = y;
    in_last = last;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_acc", 32'(acc_out), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_term_count", 32'(term_count), 0);
    send(3, 4, 0);
    chk("t2_mid_out_valid", 32'(out_valid), 0);
    chk("t2_mid_acc", 32'(acc_out), 12);
    send(5, 6, 0);
    send(2, 7, 1);
    chk("t2_out_valid", 32'(out_valid), 1);
    chk("t2_acc", 32'(acc_out), 56);
    chk("t2_term_count", 32'(term_count), 3);
    chk("t2_overflow", 32'(overflow), 0);
    a = 9;
    b = 9;
    in_last = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_acc", 32'(acc_out), 56);
      chk("t3_hold_in_ready", 32'(in_ready), 0);
      chk("t3_hold_out_valid", 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    consume();
    chk("t3_post_out_valid", 32'(out_valid), 0);
    chk("t3_post_in_ready", 32'(in_ready), 1);
    chk("t3_post_acc", 32'(acc_out), 56);
    send(1, 1, 1);
    chk("t3_acc", 32'(acc_out), 1);
    chk("t3_term_count", 32'(term_count), 1);
    chk("t3_out_valid", 32'(out_valid), 1);
    consume();
    send(255, 255, 0);
    chk("t4_mid_overflow", 32'(overflow), 0);
    chk("t4_mid_acc", 32'(acc_out), 65025);
    send(255, 255, 1);
    chk("t4_overflow", 32'(overflow), 1);
`ifdef MAC_ACC_SATURATE_EN
    chk("t4_acc", 32'(acc_out), 65535);
`else
    chk("t4_acc", 32'(acc_out), 64514);
`endif
    chk("t4_term_count", 32'(term_count), 2);
    consume();
    send(0, 0, 1);
    chk("t4_next_overflow", 32'(overflow), 0);
    chk("t4_next_acc", 32'(acc_out), 0);
    consume();
    for (int i = 0; i < 3; i++) send(1, 1, 0);
    chk("t5_pre_out_valid", 32'(out_valid), 0);
    chk("t5_pre_acc", 32'(acc_out), 3);
    send(1, 1, 0);
    chk("t5_out_valid", 32'(out_valid), 1);
    chk("t5_acc", 32'(acc_out), 4);
    chk("t5_term_count", 32'(term_count), 4);
    chk("t5_in_ready", 32'(in_ready), 0);
    tick();
    chk("t5_wait_in_ready", 32'(in_ready), 0);
    chk("t5_wait_acc", 32'(acc_out), 4);
    consume();
    chk("t5_post_in_ready", 32'(in_ready), 1);
    send(9, 9, 0);
    send(9, 9, 0);
    chk("t6_mid_acc", 32'(acc_out), 162);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_out_valid", 32'(out_valid), 0);
    chk("t6_rst_term_count", 32'(term_count), 0);
    chk("t6_rst_in_ready", 32'(in_ready), 1);
    send(2, 3, 1);
    chk("t6_acc", 32'(acc_out), 6);
    chk("t6_term_count", 32'(term_count), 1);
    chk("t6_out_valid", 32'(out_valid), 1);
    chk("t6_overflow", 32'(overflow), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
